// File: rtl/spi_reg_ctrl.sv
// Register-bank controller behind the SPI deserializer: decodes completed
// transactions into config registers, stages duty-cycle writes to PWM period boundaries.
module spi_reg_ctrl #(
    parameter int NUM_REGS  = 5,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 txn_read_write,
    input  logic [6:0]           txn_addr,
    input  logic [7:0]           txn_data,
    input  logic                 txn_valid,
    input  logic                 pwm_sync,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic                 cfg_update,
    output logic                 busy,
    output logic                 duty_pending,
    output logic [7:0]           txn_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    // state  | meaning
    // IDLE   | waiting for a txn_valid rising edge
    // DECODE | classify captured transaction
    // APPLY  | write register / stage duty, update counters
    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_APPLY} state_t;
    typedef enum logic [1:0] {CLS_READ, CLS_WRITE, CLS_ERR} cls_t;

    localparam logic [6:0]           NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    state_t               state_q, state_d;
    cls_t                 cls_q, cls_d;
    logic                 valid_d_q, valid_d_d;
    logic                 rw_q, rw_d;
    logic [6:0]           addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           reg0_q, reg0_d;
    logic [7:0]           reg1_q, reg1_d;
    logic [7:0]           reg2_q, reg2_d;
    logic [7:0]           reg3_q, reg3_d;
    logic [7:0]           duty_q, duty_d;
    logic [7:0]           shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 cfg_update_q, cfg_update_d;
    logic [7:0]           txn_count_q, txn_count_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 start;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   err_sum;

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        valid_d_d    = txn_valid;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        reg0_d       = reg0_q;
        reg1_d       = reg1_q;
        reg2_d       = reg2_q;
        reg3_d       = reg3_q;
        duty_d       = duty_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        cfg_update_d = 1'b0;
        txn_count_d  = txn_count_q;
        err_inc      = 2'd0;
        start        = txn_valid & ~valid_d_q;

        // Commit first so a coinciding duty write below re-arms with the new value.
        if (pwm_sync && pending_q) begin
            duty_d       = shadow_q;
            pending_d    = 1'b0;
            cfg_update_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rw_d    = txn_read_write;
                    addr_d  = txn_addr;
                    data_d  = txn_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!rw_q)                    cls_d = CLS_READ;
                else if (addr_q < NUM_REGS_A) cls_d = CLS_WRITE;
                else                          cls_d = CLS_ERR;
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                txn_count_d = txn_count_q + 8'd1;
                if (cls_q == CLS_ERR) err_inc = err_inc + 2'd1;
                if (cls_q == CLS_WRITE) begin
                    case (addr_q)
                        7'd0: begin reg0_d = data_q; cfg_update_d = 1'b1; end
                        7'd1: begin reg1_d = data_q; cfg_update_d = 1'b1; end
                        7'd2: begin reg2_d = data_q; cfg_update_d = 1'b1; end
                        7'd3: begin reg3_d = data_q; cfg_update_d = 1'b1; end
                        7'd4: begin shadow_d = data_q; pending_d = 1'b1; end
                        default: ;
                    endcase
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start && state_q != ST_IDLE) err_inc = err_inc + 2'd1;

        err_sum = {1'b0, err_count_q} + (ERR_CNT_W+1)'(err_inc);
        if (err_sum > {1'b0, ERR_MAX}) err_count_d = ERR_MAX;
        else                           err_count_d = err_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cls_q        <= CLS_READ;
            valid_d_q    <= 1'b1;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            reg0_q       <= '0;
            reg1_q       <= '0;
            reg2_q       <= '0;
            reg3_q       <= '0;
            duty_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            cfg_update_q <= 1'b0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            valid_d_q    <= valid_d_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            reg0_q       <= reg0_d;
            reg1_q       <= reg1_d;
            reg2_q       <= reg2_d;
            reg3_q       <= reg3_d;
            duty_q       <= duty_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            cfg_update_q <= cfg_update_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign en_reg_out_7_0  = reg0_q;
    assign en_reg_out_15_8 = reg1_q;
    assign en_reg_pwm_7_0  = reg2_q;
    assign en_reg_pwm_15_8 = reg3_q;
    assign pwm_duty_cycle  = duty_q;
    assign cfg_update      = cfg_update_q;
    assign busy            = (state_q != ST_IDLE);
    assign duty_pending    = pending_q;
    assign txn_count       = txn_count_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txn_read_write = 1'b0;
    logic [6:0] txn_addr = '0;
    logic [7:0] txn_data = '0;
    logic       txn_valid = 1'b0;
    logic       pwm_sync = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle, txn_count;
    logic       cfg_update, busy, duty_pending;
    logic [3:0] err_count;

    int total = 0;
    int bad = 0;
    int cfg_cnt = 0;
    int c0;

    spi_reg_ctrl #(.NUM_REGS(5), .ERR_CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .txn_read_write(txn_read_write), .txn_addr(txn_addr), .txn_data(txn_data),
        .txn_valid(txn_valid), .pwm_sync(pwm_sync),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .cfg_update(cfg_update), .busy(busy),
        .duty_pending(duty_pending), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_update === 1'b1) cfg_cnt++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_txn(input logic rw, input logic [6:0] a, input logic [7:0] d);
        txn_read_write = rw;
        txn_addr = a;
        txn_data = d;
        txn_valid = 1'b1;
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] a, input logic [7:0] d);
        start_txn(rw, a, d);
        tick(3);
        txn_valid = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        txn_valid = 1'b0;
        pwm_sync = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (en_reg_out_7_0 !== 8'h00) begin bad++; $display("FAIL rst_reg0 got=%0h exp=0", en_reg_out_7_0); end
        total++; if (en_reg_pwm_15_8 !== 8'h00) begin bad++; $display("FAIL rst_reg3 got=%0h exp=0", en_reg_pwm_15_8); end
        total++; if (pwm_duty_cycle !== 8'h00) begin bad++; $display("FAIL rst_duty got=%0h exp=0", pwm_duty_cycle); end
        total++; if ({cfg_update, busy, duty_pending} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {cfg_update, busy, duty_pending}); end
        total++; if (txn_count !== 8'd0 || err_count !== 4'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", txn_count, err_count); end
    endtask

    task automatic test_write_hold();
        c0 = cfg_cnt;
        start_txn(1'b1, 7'h00, 8'hA5);
        tick(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy1 got=%b exp=1", busy); end
        tick(1);
        total++; if (busy !== 1'b1 || en_reg_out_7_0 !== 8'h00) begin bad++; $display("FAIL wr_t2 got busy=%b reg=%0h exp 1/0", busy, en_reg_out_7_0); end
        tick(1);
        total++; if (en_reg_out_7_0 !== 8'hA5) begin bad++; $display("FAIL wr_reg0 got=%0h exp=a5", en_reg_out_7_0); end
        total++; if (cfg_update !== 1'b1) begin bad++; $display("FAIL wr_cfg got=%b exp=1", cfg_update); end
        total++; if (txn_count !== 8'd1) begin bad++; $display("FAIL wr_txn got=%0d exp=1", txn_count); end
        tick(7);
        total++; if (txn_count !== 8'd1 || busy !== 1'b0) begin bad++; $display("FAIL wr_hold got txn=%0d busy=%b exp 1/0", txn_count, busy); end
        total++; if (cfg_cnt - c0 !== 1) begin bad++; $display("FAIL wr_cfg_pulses got=%0d exp=1", cfg_cnt - c0); end
        txn_valid = 1'b0;
        tick(1);
    endtask

    task automatic test_read();
        c0 = cfg_cnt;
        run_txn(1'b0, 7'h02, 8'hFF);
        tick(1);
        total++; if (en_reg_pwm_7_0 !== 8'h00) begin bad++; $display("FAIL rd_reg2 got=%0h exp=0", en_reg_pwm_7_0); end
        total++; if (txn_count !== 8'd2 || err_count !== 4'd0) begin bad++; $display("FAIL rd_counts got=%0d/%0d exp=2/0", txn_count, err_count); end
        total++; if (cfg_cnt - c0 !== 0) begin bad++; $display("FAIL rd_cfg got=%0d exp=0", cfg_cnt - c0); end
    endtask

    task automatic test_regs();
        run_txn(1'b1, 7'h01, 8'h3C);
        run_txn(1'b1, 7'h03, 8'hC3);
        total++; if (en_reg_out_15_8 !== 8'h3C || en_reg_pwm_15_8 !== 8'hC3) begin bad++; $display("FAIL regs got=%0h/%0h exp=3c/c3", en_reg_out_15_8, en_reg_pwm_15_8); end
        total++; if (txn_count !== 8'd4) begin bad++; $display("FAIL regs_txn got=%0d exp=4", txn_count); end
    endtask

    task automatic test_errors();
        c0 = cfg_cnt;
        run_txn(1'b1, 7'h05, 8'h11);
        run_txn(1'b1, 7'h7F, 8'h22);
        total++; if (err_count !== 4'd2) begin bad++; $display("FAIL err_two got=%0d exp=2", err_count); end
        total++; if (en_reg_out_7_0 !== 8'hA5 || pwm_duty_cycle !== 8'h00 || duty_pending !== 1'b0) begin bad++; $display("FAIL err_noreg got=%0h/%0h/%b", en_reg_out_7_0, pwm_duty_cycle, duty_pending); end
        total++; if (cfg_cnt - c0 !== 0) begin bad++; $display("FAIL err_cfg got=%0d exp=0", cfg_cnt - c0); end
        for (int i = 0; i < 20; i++) run_txn(1'b1, 7'h10, 8'h00);
        total++; if (err_count !== 4'd15) begin bad++; $display("FAIL err_sat got=%0d exp=15", err_count); end
        total++; if (txn_count !== 8'd26) begin bad++; $display("FAIL err_txn got=%0d exp=26", txn_count); end
    endtask

    task automatic test_duty();
        run_txn(1'b1, 7'h04, 8'h40);
        run_txn(1'b1, 7'h04, 8'h80);
        total++; if (duty_pending !== 1'b1 || pwm_duty_cycle !== 8'h00) begin bad++; $display("FAIL duty_stage got=%b/%0h exp 1/0", duty_pending, pwm_duty_cycle); end
        c0 = cfg_cnt;
        pwm_sync = 1'b1;
        tick(1);
        pwm_sync = 1'b0;
        total++; if (pwm_duty_cycle !== 8'h80 || duty_pending !== 1'b0) begin bad++; $display("FAIL duty_commit got=%0h/%b exp 80/0", pwm_duty_cycle, duty_pending); end
        total++; if (cfg_update !== 1'b1) begin bad++; $display("FAIL duty_cfg got=%b exp=1", cfg_update); end
        tick(2);
        total++; if (cfg_cnt - c0 !== 1) begin bad++; $display("FAIL duty_pulses got=%0d exp=1", cfg_cnt - c0); end
    endtask

    task automatic test_duty_coincide();
        run_txn(1'b1, 7'h04, 8'h11);
        start_txn(1'b1, 7'h04, 8'h22);
        tick(2);
        pwm_sync = 1'b1;
        tick(1);
        pwm_sync = 1'b0;
        txn_valid = 1'b0;
        total++; if (pwm_duty_cycle !== 8'h11 || duty_pending !== 1'b1) begin bad++; $display("FAIL coin_commit got=%0h/%b exp 11/1", pwm_duty_cycle, duty_pending); end
        total++; if (cfg_update !== 1'b1) begin bad++; $display("FAIL coin_cfg got=%b exp=1", cfg_update); end
        tick(2);
        pwm_sync = 1'b1;
        tick(1);
        pwm_sync = 1'b0;
        total++; if (pwm_duty_cycle !== 8'h22 || duty_pending !== 1'b0) begin bad++; $display("FAIL coin_next got=%0h/%b exp 22/0", pwm_duty_cycle, duty_pending); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_txn(1'b1, 7'h00, 8'h5A);
        tick(1);
        txn_valid = 1'b0;
        tick(1);
        txn_valid = 1'b1;
        tick(1);
        total++; if (en_reg_out_7_0 !== 8'h5A) begin bad++; $display("FAIL drop_reg got=%0h exp=5a", en_reg_out_7_0); end
        total++; if (txn_count !== 8'd1 || err_count !== 4'd1) begin bad++; $display("FAIL drop_counts got=%0d/%0d exp=1/1", txn_count, err_count); end
        tick(3);
        txn_valid = 1'b0;
        tick(1);
        total++; if (busy !== 1'b0 || txn_count !== 8'd1) begin bad++; $display("FAIL drop_after got=%b/%0d exp 0/1", busy, txn_count); end
    endtask

    task automatic test_reset_cases();
        rst = 1'b1;
        start_txn(1'b1, 7'h01, 8'h77);
        tick(2);
        rst = 1'b0;
        tick(4);
        total++; if (txn_count !== 8'd0 || busy !== 1'b0 || en_reg_out_15_8 !== 8'h00) begin bad++; $display("FAIL stale got=%0d/%b/%0h exp 0/0/0", txn_count, busy, en_reg_out_15_8); end
        txn_valid = 1'b0;
        tick(1);
        start_txn(1'b1, 7'h01, 8'h77);
        tick(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_decode got=%b exp=1", busy); end
        rst = 1'b1;
        txn_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || en_reg_out_15_8 !== 8'h00) begin bad++; $display("FAIL mid_rst got=%b/%0h exp 0/0", busy, en_reg_out_15_8); end
        tick(3);
        total++; if (en_reg_out_15_8 !== 8'h00 || txn_count !== 8'd0 || err_count !== 4'd0 || cfg_update !== 1'b0) begin bad++; $display("FAIL mid_after got=%0h/%0d/%0d/%b", en_reg_out_15_8, txn_count, err_count, cfg_update); end
    endtask

    initial begin
        test_reset();
        test_write_hold();
        test_read();
        test_regs();
        test_errors();
        test_duty();
        test_duty_coincide();
        test_back_to_back();
        test_reset_cases();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
